car_direction_fsm: RTL and testbench
====================================

Name: car_direction_fsm

Overview:
- Parking-entrance front end. Synchronises and debounces two optical barrier sensors, sensor_a (outer) and sensor_b (inner).
- Tracks each car's passage through the barrier pair with an FSM.
- Emits a one-cycle count pulse plus a direction flag. These drive en/up of the downstream two-digit BCD occupancy counter directly.
- Flags aborted or illegal sensor sequences on a separate error pulse.

Parameters:
DEBOUNCE, 4, consecutive cycles a synchronised sensor must differ from its debounced value before the debounced value changes (>=1)
TIMEOUT, 1000, cycles without a debounced change allowed in any in-transit state before abort (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
sensor_a  input  1  raw outer barrier, 1 = beam blocked, asynchronous to clk
sensor_b  input  1  raw inner barrier, 1 = beam blocked, asynchronous to clk
en  output  1  one-cycle pulse per completed passage; connects to counter en
up  output  1  direction of last passage: 1 = entry (count up), 0 = exit; connects to counter up
err  output  1  one-cycle pulse on illegal sequence or timeout
busy  output  1  high whenever FSM is not in IDLE

Behaviour:
- Reset (async, rst=1): both 2-FF synchronisers = 0, debounced a/b = 0, debounce counters = 0, timer = 0, state = IDLE, en = 0, err = 0, up = 1, busy = 0.
- Reset mid-passage discards the passage; no pulse is emitted.
- Synchroniser: 2 flops per sensor. Raw value captured at edge k is available as sync at edge k+1.
- Debounce, per sensor:
  - Any cycle sync == deb clears the counter.
  - Otherwise the counter increments.
  - When sync != deb for DEBOUNCE consecutive cycles, deb <= sync and the counter clears.
  - Glitches shorter than DEBOUNCE cycles never reach the FSM.
- FSM input is the pair ab = {deb_a, deb_b}. All outputs are registered.
- States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLEAR.
- Entry path: IDLE -ab=10-> IN_A -11-> IN_AB -01-> IN_B -00-> IDLE, with en=1, up=1.
- Exit path: IDLE -ab=01-> OUT_B -11-> OUT_BA -10-> OUT_A -00-> IDLE, with en=1, up=0.
- Backing up (legal, no pulse):
  - IN_AB -10-> IN_A; IN_B -11-> IN_AB; IN_A -00-> IDLE.
  - OUT_BA -01-> OUT_B; OUT_A -11-> OUT_BA; OUT_B -00-> IDLE.
- Illegal transitions pulse err=1 and go to WAIT_CLEAR:
  - both debounced bits change on the same cycle;
  - IDLE sees 11;
  - IN_A sees 01, IN_B sees 10, OUT_B sees 10, OUT_A sees 01.
- WAIT_CLEAR: stays until ab = 00, then goes to IDLE. No en pulses while in it. err is not repeated.
- Timeout: timer clears on every debounced change and in IDLE/WAIT_CLEAR. In any IN_*/OUT_* state, reaching TIMEOUT unchanged cycles pulses err and enters WAIT_CLEAR.
- en and err are each high for exactly one cycle and are never high on the same cycle.
- up updates only on the cycle en is asserted; otherwise it holds.
- busy = (state != IDLE), registered with state.
- Latency: a final raw sensor change captured at edge k yields en high on the cycle after edge k+1+DEBOUNCE+1.
- No saturation logic: counter wrap at 99/00 is the counter's concern.

Test Plan:
- Entry, DEBOUNCE=2: raw ab 00->10->11->01->00, each held 10 cycles -> exactly one en pulse with up=1, err=0. en rises 4 edges after the raw 01->00 capture edge.
- Exit: raw ab 00->01->11->10->00, each held 10 cycles -> one en pulse with up=0. up remains 0 afterwards, and busy falls on the same edge en rises.
- Glitch and back-up: 1-cycle pulses on sensor_a while idle -> no activity. Then a car goes 10->11->10->00 (backs out) -> busy pulses, en=0, err=0.
- Illegal:
  - ab 00->11 directly -> one err pulse, state WAIT_CLEAR.
  - Hold 11 for 50 cycles -> no further err.
  - Release to 00 -> IDLE; a following legal entry counts normally.
- Timeout, TIMEOUT=20: hold 10 for 40 cycles -> err exactly 20 cycles after the debounced 10 edge, then WAIT_CLEAR until 00.
- Reset mid-operation: assert rst asynchronously in IN_AB -> outputs immediately at reset values (up=1, en=0, busy=0). Sensors released during reset -> no en after release.

Source files
------------

// File: rtl/car_direction_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : car_direction_fsm
//  Description : Parking-entrance front end. Synchronises and debounces the
//                outer (sensor_a) and inner (sensor_b) optical barriers,
//                tracks each car through the barrier pair and reports every
//                completed passage as a one-cycle count pulse plus direction.
//                Aborted or illegal sequences raise a one-cycle error pulse.
//  Ports       : clk      - system clock, rising edge
//                rst      - asynchronous reset, active-high
//                sensor_a - raw outer barrier, 1 = blocked, async to clk
//                sensor_b - raw inner barrier, 1 = blocked, async to clk
//                en       - one-cycle pulse per completed passage
//                up       - direction of last passage (1 = entry, 0 = exit)
//                err      - one-cycle pulse on illegal sequence or timeout
//                busy     - high whenever the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module car_direction_fsm #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic en,
    output logic up,
    output logic err,
    output logic busy
);

    localparam int c_DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int c_TMR_W = $clog2(TIMEOUT);
    localparam logic [c_DEB_W-1:0] c_DEB_MAX = c_DEB_W'(DEBOUNCE - 1);
    // The timer is cleared on the edge the FSM first sees a new debounced
    // value, which is already one cycle after the debounced change itself.
    // Firing at TIMEOUT-2 therefore lands the error pulse exactly TIMEOUT
    // cycles after the debounced change.
    localparam logic [c_TMR_W-1:0] c_TMO_MAX = c_TMR_W'(TIMEOUT - 2);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_IN_A       = 3'd1;
    localparam logic [2:0] c_IN_AB      = 3'd2;
    localparam logic [2:0] c_IN_B       = 3'd3;
    localparam logic [2:0] c_OUT_B      = 3'd4;
    localparam logic [2:0] c_OUT_BA     = 3'd5;
    localparam logic [2:0] c_OUT_A      = 3'd6;
    localparam logic [2:0] c_WAIT_CLEAR = 3'd7;

    logic [1:0] w_raw;
    logic [1:0] w_ab;   // {deb_a, deb_b}

    assign w_raw = {sensor_a, sensor_b};

    // ------------------------------------------------------------------
    // Per-sensor 2-FF synchroniser and debouncer
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
            logic               r_meta;
            logic               r_sync;
            logic               r_deb;
            logic [c_DEB_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                    r_deb  <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                    if (r_sync == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_MAX) begin
                        r_deb <= r_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_ab[gi] = r_deb;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Passage FSM
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [1:0]         r_ab_prev;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_en;
    logic               r_err;
    logic               r_up;
    logic               r_busy;
    logic               w_en_nxt;
    logic               w_err_nxt;
    logic               w_up_nxt;
    logic               w_changed;
    logic               w_both;
    logic               w_in_transit;
    logic               w_timeout;

    assign w_changed    = (w_ab != r_ab_prev);
    assign w_both       = &(w_ab ^ r_ab_prev);
    assign w_in_transit = (r_state != c_IDLE) && (r_state != c_WAIT_CLEAR);
    assign w_timeout    = w_in_transit && !w_changed && (r_timer == c_TMO_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_up_nxt    = r_up;

        if (r_state == c_WAIT_CLEAR) begin
            if (w_ab == 2'b00) begin
                w_state_nxt = c_IDLE;
            end
        end else if (w_both) begin
            w_state_nxt = c_WAIT_CLEAR;
            w_err_nxt   = 1'b1;
        end else if (w_changed) begin
            // Any single-bit change not listed for a state is illegal.
            w_state_nxt = c_WAIT_CLEAR;
            w_err_nxt   = 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_ab == 2'b10) begin
                        w_state_nxt = c_IN_A;  w_err_nxt = 1'b0;
                    end else if (w_ab == 2'b01) begin
                        w_state_nxt = c_OUT_B; w_err_nxt = 1'b0;
                    end
                end
                c_IN_A: begin
                    if (w_ab == 2'b11) begin
                        w_state_nxt = c_IN_AB; w_err_nxt = 1'b0;
                    end else if (w_ab == 2'b00) begin
                        w_state_nxt = c_IDLE;  w_err_nxt = 1'b0;
                    end
                end
                c_IN_AB: begin
                    if (w_ab == 2'b01) begin
                        w_state_nxt = c_IN_B;  w_err_nxt = 1'b0;
                    end else if (w_ab == 2'b10) begin
                        w_state_nxt = c_IN_A;  w_err_nxt = 1'b0;
                    end
                end
                c_IN_B: begin
                    if (w_ab == 2'b00) begin
                        w_state_nxt = c_IDLE;  w_err_nxt = 1'b0;
                        w_en_nxt    = 1'b1;    w_up_nxt  = 1'b1;
                    end else if (w_ab == 2'b11) begin
                        w_state_nxt = c_IN_AB; w_err_nxt = 1'b0;
                    end
                end
                c_OUT_B: begin
                    if (w_ab == 2'b11) begin
                        w_state_nxt = c_OUT_BA; w_err_nxt = 1'b0;
                    end else if (w_ab == 2'b00) begin
                        w_state_nxt = c_IDLE;   w_err_nxt = 1'b0;
                    end
                end
                c_OUT_BA: begin
                    if (w_ab == 2'b10) begin
                        w_state_nxt = c_OUT_A;  w_err_nxt = 1'b0;
                    end else if (w_ab == 2'b01) begin
                        w_state_nxt = c_OUT_B;  w_err_nxt = 1'b0;
                    end
                end
                c_OUT_A: begin
                    if (w_ab == 2'b00) begin
                        w_state_nxt = c_IDLE;   w_err_nxt = 1'b0;
                        w_en_nxt    = 1'b1;     w_up_nxt  = 1'b0;
                    end else if (w_ab == 2'b11) begin
                        w_state_nxt = c_OUT_BA; w_err_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = c_WAIT_CLEAR;
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = c_WAIT_CLEAR;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_ab_prev <= 2'b00;
            r_timer   <= '0;
            r_en      <= 1'b0;
            r_err     <= 1'b0;
            r_up      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ab_prev <= w_ab;
            r_en      <= w_en_nxt;
            r_err     <= w_err_nxt;
            r_up      <= w_up_nxt;
            r_busy    <= (w_state_nxt != c_IDLE);
            if (!w_in_transit || w_changed) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign en   = r_en;
    assign err  = r_err;
    assign up   = r_up;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_car_direction_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_direction_fsm
//  Description : Directed bench for car_direction_fsm (DEBOUNCE=2,
//                TIMEOUT=20). Stimulus pushes expected en/err pulses into a
//                queue; a monitor pops and compares on every pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_car_direction_fsm;

    localparam int c_DEB = 2;
    localparam int c_TMO = 20;

    logic clk = 1'b0;
    logic rst;
    logic sensor_a;
    logic sensor_b;
    logic en;
    logic up;
    logic err;
    logic busy;

    car_direction_fsm #(
        .DEBOUNCE (c_DEB),
        .TIMEOUT  (c_TMO)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .en       (en),
        .up       (up),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        bit up;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; new raw value is captured on the next posedge.
    task automatic drive(input bit a, input bit b, output int t0);
        sensor_a = a;
        sensor_b = b;
        t0 = cyc;
    endtask

    // A full passage; the last raw change to 00 yields en on cycle t0+5
    // (capture edge t0+1, two sync/debounce stages, one registered output).
    task automatic do_pass(input bit entry);
        int t;
        exp_t e;
        drive(entry ? 1'b1 : 1'b0, entry ? 1'b0 : 1'b1, t); wait_cyc(10);
        drive(1'b1, 1'b1, t);                              wait_cyc(10);
        drive(entry ? 1'b0 : 1'b1, entry ? 1'b1 : 1'b0, t); wait_cyc(10);
        drive(1'b0, 1'b0, t);
        e.is_err = 1'b0; e.up = entry; e.cyc = t + 5;
        q.push_back(e);
        wait_cyc(10);
    endtask

    initial begin
        rst      = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        fork
            begin : stim
                int   t;
                exp_t e;
                wait_cyc(3);
                check("rst_en",   en,   0);
                check("rst_err",  err,  0);
                check("rst_up",   up,   1);
                check("rst_busy", busy, 0);
                rst = 1'b0;
                wait_cyc(5);

                // Entry, with a busy probe mid-passage
                drive(1'b1, 1'b0, t); wait_cyc(10);
                check("entry_busy_mid", busy, 1);
                drive(1'b1, 1'b1, t); wait_cyc(10);
                drive(1'b0, 1'b1, t); wait_cyc(10);
                drive(1'b0, 1'b0, t);
                e.is_err = 1'b0; e.up = 1'b1; e.cyc = t + 5;
                q.push_back(e);
                wait_cyc(10);
                check("entry_busy_end", busy, 0);
                check("entry_up_hold",  up,   1);

                // Exit
                do_pass(1'b0);
                check("exit_up_hold",  up,   0);
                check("exit_busy_end", busy, 0);

                // Single-cycle glitches on sensor_a while idle
                for (int i = 0; i < 3; i++) begin
                    drive(1'b1, 1'b0, t); wait_cyc(1);
                    drive(1'b0, 1'b0, t); wait_cyc(6);
                    check("glitch_busy", busy, 0);
                end

                // Car enters partway then backs out
                drive(1'b1, 1'b0, t); wait_cyc(10);
                drive(1'b1, 1'b1, t); wait_cyc(10);
                check("backup_busy_mid", busy, 1);
                drive(1'b1, 1'b0, t); wait_cyc(10);
                drive(1'b0, 1'b0, t); wait_cyc(10);
                check("backup_busy_end", busy, 0);
                check("backup_up_hold",  up,   0);

                // Illegal 00 -> 11, long hold, release, then a normal entry
                drive(1'b1, 1'b1, t);
                e.is_err = 1'b1; e.up = 1'b0; e.cyc = t + 5;
                q.push_back(e);
                wait_cyc(50);
                check("illegal_wait_busy", busy, 1);
                drive(1'b0, 1'b0, t); wait_cyc(10);
                check("illegal_clear_busy", busy, 0);
                do_pass(1'b1);
                check("after_illegal_up", up, 1);

                // Timeout: debounced 10 at edge t+4, err 20 cycles later
                drive(1'b1, 1'b0, t);
                e.is_err = 1'b1; e.up = 1'b0; e.cyc = t + 4 + c_TMO;
                q.push_back(e);
                wait_cyc(40);
                check("timeout_wait_busy", busy, 1);
                drive(1'b0, 1'b0, t); wait_cyc(10);
                check("timeout_clear_busy", busy, 0);

                // Asynchronous reset in IN_AB, after an exit left up=0
                do_pass(1'b0);
                check("pre_reset_up", up, 0);
                drive(1'b1, 1'b0, t); wait_cyc(10);
                drive(1'b1, 1'b1, t); wait_cyc(10);
                check("pre_reset_busy", busy, 1);
                #2 rst = 1'b1;
                #1;
                check("async_rst_en",   en,   0);
                check("async_rst_up",   up,   1);
                check("async_rst_busy", busy, 0);
                check("async_rst_err",  err,  0);
                sensor_a = 1'b0;
                sensor_b = 1'b0;
                wait_cyc(5);
                rst = 1'b0;
                wait_cyc(30);
                check("post_reset_busy", busy, 0);
                check("post_reset_up",   up,   1);
                done = 1'b1;
            end
            begin : mon
                exp_t m;
                while (!done) begin
                    @(negedge clk);
                    if (!rst && (en || err)) begin
                        check("en_err_exclusive", (en && err) ? 1 : 0, 0);
                        if (q.size() == 0) begin
                            check("unexpected_pulse", {30'd0, err, en}, 0);
                        end else begin
                            m = q.pop_front();
                            check("pulse_is_err", err, m.is_err);
                            check("pulse_cycle", cyc, m.cyc);
                            if (en) begin
                                check("pulse_up",   up,   m.up);
                                check("busy_at_en", busy, 0);
                            end
                        end
                    end
                end
            end
        join
        check("pending_expectations", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
